// File: rtl/ppfifo_axi_stream_arbiter.sv
// ppfifo_axi_stream_arbiter
//
// Packet-granular round-robin arbiter. It shares one AXI Stream master among
// NUM_CH ping-pong FIFO read ports. One FIFO buffer is granted at a time and
// is streamed out in full before the next grant. The source channel is
// tagged in TUSER[2:1], and the start-of-frame flag is carried in TUSER[0].
//
// Ports
//   i_axi_clk      clock for all logic
//   rst            synchronous, active-high reset
//   i_ppfifo_rdy   per-channel buffer-ready
//   o_ppfifo_act   per-channel activate (registered, at most one bit set)
//   i_ppfifo_size  per-channel buffer word count, 24 bits per channel
//   i_ppfifo_data  per-channel read data, DATA_WIDTH+1 bits per channel (MSB = SOF)
//   o_ppfifo_stb   per-channel read strobe (combinational)
//   i_axi_ready    TREADY
//   o_axi_valid    TVALID (combinational)
//   o_axi_data     TDATA
//   o_axi_last     TLAST
//   o_axi_user     TUSER: [0] SOF, [2:1] granted channel, [3] zero
//   o_busy         high whenever the arbiter is not idle
module ppfifo_axi_stream_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2
) (
    input  logic                             i_axi_clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                i_ppfifo_rdy,
    output logic [NUM_CH-1:0]                o_ppfifo_act,
    input  logic [24*NUM_CH-1:0]             i_ppfifo_size,
    input  logic [(DATA_WIDTH+1)*NUM_CH-1:0] i_ppfifo_data,
    output logic [NUM_CH-1:0]                o_ppfifo_stb,
    input  logic                             i_axi_ready,
    output logic                             o_axi_valid,
    output logic [DATA_WIDTH-1:0]            o_axi_data,
    output logic                             o_axi_last,
    output logic [3:0]                       o_axi_user,
    output logic                             o_busy
);

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    r_grant;
    logic [1:0]    r_last_grant;
    logic [23:0]   r_size;
    logic [23:0]   r_count;

    logic              found;
    logic [1:0]        pick;
    logic [23:0]       pick_size;
    logic [DATA_WIDTH:0] cur_data;
    logic              in_send;
    logic              hs;
    logic              done;

    // Channel that sits 'off' positions after 'base' in round-robin order.
    function automatic logic [1:0] wrap_ch(input logic [1:0] base, input int off);
        int v;
        v = (int'(base) + off) % NUM_CH;
        return 2'(v);
    endfunction

    // Round-robin search: start just after the last grant and wrap. The inner
    // loop over constant channel numbers keeps every vector index static.
    always_comb begin
        found     = 1'b0;
        pick      = r_last_grant;
        pick_size = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!found && (2'(c) == wrap_ch(r_last_grant, off)) &&
                    i_ppfifo_rdy[c] && !o_ppfifo_act[c]) begin
                    found     = 1'b1;
                    pick      = 2'(c);
                    pick_size = i_ppfifo_size[24*c +: 24];
                end
            end
        end
    end

    // Read-data mux for the granted channel.
    always_comb begin
        cur_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_grant == 2'(c)) begin
                cur_data = i_ppfifo_data[c*(DATA_WIDTH+1) +: DATA_WIDTH+1];
            end
        end
    end

    // Streaming outputs. Valid already implies r_size > 0, so r_size-1 in
    // the last comparison never underflows while it matters.
    always_comb begin
        in_send     = (state == SEND);
        o_axi_valid = in_send && (r_count < r_size);
        o_axi_last  = o_axi_valid && (r_count == r_size - 24'd1);
        hs          = o_axi_valid && i_axi_ready;
        // r_count >= r_size also ends a zero-size buffer without a beat.
        done        = (hs && o_axi_last) || (r_count >= r_size);
        o_axi_data  = in_send ? cur_data[DATA_WIDTH-1:0] : '0;
        o_axi_user  = in_send ? {1'b0, r_grant, o_axi_valid & cur_data[DATA_WIDTH]} : 4'b0000;
        o_busy      = (state != IDLE);
        o_ppfifo_stb = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_ppfifo_stb[c] = hs && (r_grant == 2'(c));
        end
    end

    // Next-state logic. RELEASE gives the FIFO a dead cycle to swap buffers.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = SEND;
            SEND:    if (done)  state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_axi_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant and packet bookkeeping; the size is latched at grant time.
    always_ff @(posedge i_axi_clk) begin
        if (rst) begin
            o_ppfifo_act <= '0;
            r_grant      <= '0;
            r_last_grant <= 2'(NUM_CH - 1);
            r_size       <= '0;
            r_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        r_grant      <= pick;
                        r_last_grant <= pick;
                        r_size       <= pick_size;
                        r_count      <= '0;
                        o_ppfifo_act <= NUM_CH'(1) << pick;
                    end
                end
                SEND: begin
                    if (hs)   r_count      <= r_count + 24'd1;
                    if (done) o_ppfifo_act <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ppfifo_axi_stream_arbiter.sv
// Testbench for ppfifo_axi_stream_arbiter: two instances (NUM_CH=2 and
// NUM_CH=4) behind behavioural ping-pong FIFO models. Stimulus pushes the
// expected beats into a scoreboard queue; a negedge monitor pops and compares.
module tb_ppfifo_axi_stream_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ready;
    logic sel;

    // Instance A: NUM_CH = 2
    logic [1:0]  rdy_a, act_a, stb_a;
    logic [23:0] size_a [2];
    logic [47:0] size_bus_a;
    logic [65:0] data_bus_a;
    logic        valid_a, last_a, busy_a;
    logic [31:0] dout_a;
    logic [3:0]  user_a;

    // Instance B: NUM_CH = 4
    logic [3:0]   rdy_b, act_b, stb_b;
    logic [23:0]  size_b [4];
    logic [95:0]  size_bus_b;
    logic [131:0] data_bus_b;
    logic         valid_b, last_b, busy_b;
    logic [31:0]  dout_b;
    logic [3:0]   user_b;

    function automatic logic [32:0] word(input int c, input int i);
        logic [31:0] w;
        w = 32'hA000_0000 + 32'(c * 256 + i);
        return {(i == 0), w};
    endfunction

    // FIFO models: a fresh buffer whenever act is low, advance on strobe.
    for (genvar c = 0; c < 2; c++) begin : g_a
        logic [7:0] ptr;
        assign size_bus_a[24*c +: 24] = size_a[c];
        assign data_bus_a[33*c +: 33] = word(c, int'(ptr));
        always_ff @(posedge clk) begin
            if (!act_a[c])     ptr <= '0;
            else if (stb_a[c]) ptr <= ptr + 8'd1;
        end
    end
    for (genvar c = 0; c < 4; c++) begin : g_b
        logic [7:0] ptr;
        assign size_bus_b[24*c +: 24] = size_b[c];
        assign data_bus_b[33*c +: 33] = word(c, int'(ptr));
        always_ff @(posedge clk) begin
            if (!act_b[c])     ptr <= '0;
            else if (stb_b[c]) ptr <= ptr + 8'd1;
        end
    end

    ppfifo_axi_stream_arbiter #(.DATA_WIDTH(32), .NUM_CH(2)) dut_a (
        .i_axi_clk(clk), .rst(rst),
        .i_ppfifo_rdy(rdy_a), .o_ppfifo_act(act_a),
        .i_ppfifo_size(size_bus_a), .i_ppfifo_data(data_bus_a),
        .o_ppfifo_stb(stb_a), .i_axi_ready(ready),
        .o_axi_valid(valid_a), .o_axi_data(dout_a), .o_axi_last(last_a),
        .o_axi_user(user_a), .o_busy(busy_a)
    );

    ppfifo_axi_stream_arbiter #(.DATA_WIDTH(32), .NUM_CH(4)) dut_b (
        .i_axi_clk(clk), .rst(rst),
        .i_ppfifo_rdy(rdy_b), .o_ppfifo_act(act_b),
        .i_ppfifo_size(size_bus_b), .i_ppfifo_data(data_bus_b),
        .o_ppfifo_stb(stb_b), .i_axi_ready(ready),
        .o_axi_valid(valid_b), .o_axi_data(dout_b), .o_axi_last(last_b),
        .o_axi_user(user_b), .o_busy(busy_b)
    );

    // Monitor view of the instance under test.
    logic        m_valid, m_last, m_busy;
    logic [31:0] m_data;
    logic [3:0]  m_user, m_stb, m_act;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_last  = sel ? last_b  : last_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_data  = sel ? dout_b  : dout_a;
    assign m_user  = sel ? user_b  : user_a;
    assign m_stb   = sel ? stb_b   : {2'b00, stb_a};
    assign m_act   = sel ? act_b   : {2'b00, act_a};

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  user;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_pkt(input int c, input int n, input int total);
        beat_t       b;
        logic [32:0] w;
        for (int i = 0; i < n; i++) begin
            w      = word(c, i);
            b.data = w[31:0];
            b.user = {1'b0, 2'(c), (i == 0)};
            b.last = (i == total - 1);
            q.push_back(b);
        end
    endtask

    // Monitor / scoreboard
    int          cyc = 0;
    int          last_cyc = 0;
    int          stb_cnt = 0;
    bit          armed = 1'b0;
    bit          chk_gap = 1'b0;
    bit          stall = 1'b0;
    logic [31:0] st_data;
    logic        st_last;
    beat_t       exp_b;

    always_ff @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (stall && m_valid) begin
                check("hold_data", 64'(m_data), 64'(st_data));
                check("hold_last", 64'(m_last), 64'(st_last));
            end
            stall   = m_valid && !ready;
            st_data = m_data;
            st_last = m_last;
            check("stb_vs_handshake", 64'(m_stb),
                  64'((m_valid && ready) ? (4'b0001 << m_user[2:1]) : 4'b0000));
            check("act_onehot0", 64'($onehot0(m_act)), 64'd1);
            if (|m_stb) stb_cnt++;
            if (m_valid && ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", {32'd0, m_data}, 64'd0);
                end else begin
                    exp_b = q.pop_front();
                    check("beat_data", 64'(m_data), 64'(exp_b.data));
                    check("beat_user", 64'(m_user), 64'(exp_b.user));
                    check("beat_last", 64'(m_last), 64'(exp_b.last));
                    if (m_user[0] && armed) begin
                        check("idle_gap", 64'(cyc - last_cyc), 64'd3);
                        armed = 1'b0;
                    end
                    if (m_last) begin
                        last_cyc = cyc;
                        armed    = chk_gap;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(output int n);
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() != 0) check("scoreboard_drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic settle;
        int k;
        k = 0;
        while (m_busy && k < 20) begin
            tick();
            k++;
        end
        check("settle_idle", 64'(m_busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit pat [5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; ready = 1'b1; sel = 1'b0;
        rdy_a = '0; rdy_b = '0;
        for (int c = 0; c < 2; c++) size_a[c] = '0;
        for (int c = 0; c < 4; c++) size_b[c] = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_act_a",   64'(act_a),   64'd0);
        check("rst_valid_a", 64'(valid_a), 64'd0);
        check("rst_busy_a",  64'(busy_a),  64'd0);
        check("rst_act_b",   64'(act_b),   64'd0);
        check("rst_busy_b",  64'(busy_b),  64'd0);

        // Single channel, 4 beats at full throughput
        size_a[0] = 24'd4;
        push_pkt(0, 4, 4);
        rdy_a = 2'b01;
        tick();
        rdy_a = 2'b00;
        check("t1_act_rise", 64'(act_a), 64'd1);
        wait_empty(n);
        check("t1_beat_cycles", 64'(n), 64'd4);
        check("t1_act_fall", 64'(act_a), 64'd0);
        check("t1_release_busy", 64'(busy_a), 64'd1);
        settle();

        // Backpressure on ch1, TREADY 1,0,0,1,1
        size_a[1] = 24'd3;
        push_pkt(1, 3, 3);
        rdy_a = 2'b10;
        tick();
        rdy_a = 2'b00;
        check("t2_act_rise", 64'(act_a), 64'd2);
        stb_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            ready = pat[i];
            tick();
        end
        ready = 1'b1;
        check("t2_stb_pulses", 64'(stb_cnt), 64'd3);
        check("t2_sb_empty", 64'(q.size()), 64'd0);
        check("t2_act_fall", 64'(act_a), 64'd0);
        settle();

        // Zero-size buffer on ch0, then ch1 with 5 words
        size_a[0] = 24'd0;
        size_a[1] = 24'd5;
        push_pkt(1, 5, 5);
        rdy_a = 2'b11;
        tick();
        check("t3_act0", 64'(act_a), 64'd1);
        check("t3_novalid0", 64'(valid_a), 64'd0);
        rdy_a = 2'b10;
        tick();
        check("t3_release_act", 64'(act_a), 64'd0);
        check("t3_novalid1", 64'(valid_a), 64'd0);
        tick();
        check("t3_idle_busy", 64'(busy_a), 64'd0);
        tick();
        check("t3_act1", 64'(act_a), 64'd2);
        rdy_a = 2'b00;
        wait_empty(n);
        check("t3_beat_cycles", 64'(n), 64'd5);
        settle();

        // Late rdy: ch1 arrives during ch0's packet
        size_a[0] = 24'd3;
        size_a[1] = 24'd2;
        push_pkt(0, 3, 3);
        push_pkt(1, 2, 2);
        chk_gap = 1'b1;
        rdy_a = 2'b01;
        tick();
        rdy_a = 2'b10;
        check("t4_act_ch0", 64'(act_a), 64'd1);
        tick();
        check("t4_ch1_pending", 64'(act_a), 64'd1);
        n = 0;
        while (!act_a[1] && n < 20) begin
            tick();
            n++;
        end
        check("t4_ch1_granted", 64'(act_a), 64'd2);
        rdy_a = 2'b00;
        wait_empty(n);
        settle();
        chk_gap = 1'b0;

        // Mid-packet reset after beat 2 of 6
        size_a[0] = 24'd6;
        push_pkt(0, 3, 6);
        push_pkt(0, 6, 6);
        rdy_a = 2'b01;
        tick();
        check("t5_act", 64'(act_a), 64'd1);
        repeat (3) tick();
        rst = 1'b1;
        ready = 1'b0;
        tick();
        check("t5_rst_act",   64'(act_a),   64'd0);
        check("t5_rst_valid", 64'(valid_a), 64'd0);
        check("t5_rst_stb",   64'(stb_a),   64'd0);
        check("t5_rst_busy",  64'(busy_a),  64'd0);
        rst = 1'b0;
        ready = 1'b1;
        tick();
        check("t5_regrant", 64'(act_a), 64'd1);
        rdy_a = 2'b00;
        wait_empty(n);
        check("t5_beat_cycles", 64'(n), 64'd6);
        settle();

        // Fairness on the 4-channel instance
        sel = 1'b1;
        for (int c = 0; c < 4; c++) size_b[c] = 24'd2;
        push_pkt(0, 2, 2);
        push_pkt(1, 2, 2);
        push_pkt(2, 2, 2);
        push_pkt(3, 2, 2);
        push_pkt(0, 2, 2);
        chk_gap = 1'b1;
        rdy_b = 4'hF;
        wait_empty(n);
        rdy_b = 4'h0;
        settle();
        chk_gap = 1'b0;
        check("t6_act_final", 64'(act_b), 64'd0);

        repeat (5) tick();
        check("sb_final_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
